hazard_scheduler: RTL

//  Pipeline hazard controller for the 5-stage MIPS core. It generates the forwarding selects for the

---
 rtl/mips_pkg.sv | 23 ++
 rtl/md_sequencer.sv | 80 ++++++++
 rtl/hazard_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the hazard scheduler and its mult/div sequencer:
//   the ALU forwarding select encodings, the mult/div FSM state encoding and
//   the default register-specifier width.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Default register-specifier width (32 architectural registers).
    localparam int REG_ADDR_W = 5;

    // Execute-stage ALU operand select encodings.
    localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALUOutM of the memory stage

    // Mult/div sequencer states.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage : mips_pkg

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
//   Sequences one multi-cycle MULT/DIV operation at a time. An accepted start
//   moves the FSM to BUSY for exactly MD_LATENCY cycles; a registered start
//   pulse is issued on the first busy cycle (aligned with the E stage) and a
//   done pulse on the last busy cycle.
//
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   synchronous active-high reset; abandons any operation
//   accept  in   decode MULT/DIV is leaving decode this cycle
//   MdGo    out  one-cycle start pulse, the cycle after accept
//   MdBusy  out  operation in flight
//   MdDone  out  one-cycle pulse on the last busy cycle
// -----------------------------------------------------------------------------
module md_sequencer
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic CLK,
    input  logic RST,
    input  logic accept,
    output logic MdGo,
    output logic MdBusy,
    output logic MdDone
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MD_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

    md_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic                  go_q,    go_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_d    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                // A start seen while BUSY is never lost: decode is stalled
                // and the instruction is re-presented on the first IDLE cycle.
                if (accept) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                    go_d    = 1'b1;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign MdGo   = go_q;
    assign MdBusy = (state_q == MD_BUSY);
    assign MdDone = MdBusy && (cnt_q == CNT_LAST);

endmodule : md_sequencer

// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
//   Hazard controller for the 5-stage MIPS pipeline. Produces the forwarding
//   selects for the decode branch comparator and the execute ALU, the F/D
//   stall and E flush controls, and drives the mult/div sequencer so that
//   MULT/DIV and MFHI/MFLO wait in decode while an operation is in flight.
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   RsD, RtD                 decode source specifiers
//   BranchD                  decode instruction is a branch
//   MdStartD, MdReadD        decode instruction is MULT/DIV, MFHI/MFLO
//   RsE, RtE, WriteRegE      execute source / destination specifiers
//   RegWriteE, MemtoRegE     execute controls
//   WriteRegM, RegWriteM,
//   MemtoRegM                memory destination and controls
//   WriteRegW, RegWriteW     writeback destination and write enable
//   ForwardAD, ForwardBD     decode comparator select (1 = ALUOutM)
//   ForwardAE, ForwardBE     ALU operand select (FWD_RF / FWD_WB / FWD_MEM)
//   StallF, StallD, FlushE   hold PC and F/D, bubble into D/E
//   MdGo, MdBusy, MdDone     mult/div start pulse, in-flight, done pulse
// -----------------------------------------------------------------------------
module hazard_scheduler
    import mips_pkg::*;
#(
    parameter int REG_ADDR   = REG_ADDR_W,
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                CLK,
    input  logic                RST,
    // decode
    input  logic [REG_ADDR-1:0] RsD,
    input  logic [REG_ADDR-1:0] RtD,
    input  logic                BranchD,
    input  logic                MdStartD,
    input  logic                MdReadD,
    // execute
    input  logic [REG_ADDR-1:0] RsE,
    input  logic [REG_ADDR-1:0] RtE,
    input  logic [REG_ADDR-1:0] WriteRegE,
    input  logic                RegWriteE,
    input  logic                MemtoRegE,
    // memory
    input  logic [REG_ADDR-1:0] WriteRegM,
    input  logic                RegWriteM,
    input  logic                MemtoRegM,
    // writeback
    input  logic [REG_ADDR-1:0] WriteRegW,
    input  logic                RegWriteW,
    // forwarding
    output logic                ForwardAD,
    output logic                ForwardBD,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    // stall / flush
    output logic                StallF,
    output logic                StallD,
    output logic                FlushE,
    // mult/div
    output logic                MdGo,
    output logic                MdBusy,
    output logic                MdDone
);

    // $zero is hard-wired, so it never carries a dependency.
    function automatic logic reg_match(input logic [REG_ADDR-1:0] a,
                                       input logic [REG_ADDR-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    logic lwstall, brstall, mdstall, stall;
    logic md_accept;
    logic md_busy;

    // ALU forwarding: the memory stage holds the younger result, so it wins.
    always_comb begin
        ForwardAE = FWD_RF;
        if (RegWriteM && reg_match(WriteRegM, RsE))      ForwardAE = FWD_MEM;
        else if (RegWriteW && reg_match(WriteRegW, RsE)) ForwardAE = FWD_WB;

        ForwardBE = FWD_RF;
        if (RegWriteM && reg_match(WriteRegM, RtE))      ForwardBE = FWD_MEM;
        else if (RegWriteW && reg_match(WriteRegW, RtE)) ForwardBE = FWD_WB;
    end

    assign ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
    assign ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);

    // Load in E: its data is not available until after M.
    assign lwstall = MemtoRegE &&
                     (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));

    // The branch compares in D, so an ALU result still in E, or load data
    // still in M, cannot be forwarded in time.
    assign brstall = BranchD &&
                     ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                      (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));

    // Only one mult/div at a time, and HI/LO are not valid until it finishes.
    assign mdstall = (MdStartD || MdReadD) && md_busy;

    assign stall  = lwstall || brstall || mdstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // A MULT/DIV is accepted only when it actually leaves decode; the
    // sequencer additionally ignores it unless IDLE.
    assign md_accept = MdStartD && !stall;

    md_sequencer #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_md_seq (
        .CLK    (CLK),
        .RST    (RST),
        .accept (md_accept),
        .MdGo   (MdGo),
        .MdBusy (md_busy),
        .MdDone (MdDone)
    );

    assign MdBusy = md_busy;

endmodule : hazard_scheduler
